// File: rtl/rfsoc_config_pkg.sv
// Shared configuration for the RFSoC DAC waveform player.
// Holds the PS stream width, the gpio control-word bit assignments, the
// DAC word packing constants and the player FSM state type.
package rfsoc_config;

  // PS AXI-Stream beat width and DAC sample word width.
  localparam int unsigned ps_axis_width  = 32;
  localparam int unsigned dac_word_width = 128;
  localparam int unsigned beats_per_word = dac_word_width / ps_axis_width;
  localparam int unsigned beat_cnt_width = (beats_per_word > 1) ? $clog2(beats_per_word) : 1;

  // gpio control word layout.
  localparam int unsigned gpio_width       = 16;
  localparam int unsigned trigger_line     = 0;
  localparam int unsigned dac_load_enable  = 1;
  localparam int unsigned dac_buffer_flush = 2;
  localparam int unsigned dac_loop         = 3;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StPlay = 1'b1
  } dac_state_e;

  // Rising edge between two successive registered samples of a control bit.
  function automatic logic rising(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/dac_wave_mem.sv
// Waveform storage: simple dual-port RAM, one write port and one registered
// read port with read enable. Contents are deliberately not reset.
//   clk_i      clock
//   wr_en_i    write strobe; wr_data_i stored at wr_addr_i
//   rd_en_i    read strobe; rd_data_o updates one cycle later, else holds
module dac_wave_mem #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 128
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dac_wave_player.sv
// DAC waveform player: packs PS stream beats into 128-bit words, stores them
// in dac_wave_mem and replays them to the DAC stream on a gpio trigger edge.
//   clk, rst             clock, asynchronous active-low reset
//   gpio_ctrl_ext        control word (trigger/load enable/flush/loop bits)
//   s_axis_*             PS waveform beats in, first beat in the LSBs
//   m_axis_*             DAC sample words out, tvalid high after reset
//   select_in            channel select, gates loading
//   playing              FSM is in PLAY
//   word_count           number of stored 128-bit words
module dac_wave_player
  import rfsoc_config::*;
#(
  parameter int unsigned mem_depth_log2 = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [gpio_width-1:0]     gpio_ctrl_ext,
  input  logic [ps_axis_width-1:0]  s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [dac_word_width-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic                      select_in,
  output logic                      playing,
  output logic [mem_depth_log2:0]   word_count
);

  localparam int unsigned AddrW = mem_depth_log2;
  localparam int unsigned CntW  = mem_depth_log2 + 1;
  localparam int unsigned Depth = 1 << mem_depth_log2;
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);
  localparam logic [beat_cnt_width-1:0] LastBeat = beat_cnt_width'(beats_per_word - 1);

  // Control word capture; every decision below uses the registered copy.
  logic [gpio_width-1:0] gpio_ctrl_q;
  logic [1:0]            gpio_prev_q;  // {load_enable, trigger} one cycle older

  logic load_en, flush, loop_en, trig_rise, load_rise;
  logic unused_gpio;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_ctrl_q <= '0;
      gpio_prev_q <= '0;
    end else begin
      gpio_ctrl_q <= gpio_ctrl_ext;
      gpio_prev_q <= {gpio_ctrl_q[dac_load_enable], gpio_ctrl_q[trigger_line]};
    end
  end

  assign load_en     = gpio_ctrl_q[dac_load_enable];
  assign flush       = gpio_ctrl_q[dac_buffer_flush];
  assign loop_en     = gpio_ctrl_q[dac_loop];
  assign trig_rise   = rising(gpio_ctrl_q[trigger_line], gpio_prev_q[0]);
  assign load_rise   = rising(gpio_ctrl_q[dac_load_enable], gpio_prev_q[1]);
  assign unused_gpio = ^gpio_ctrl_q;

  // Load path
  dac_state_e                 state_q;
  logic                       playing_q;
  logic [AddrW-1:0]           rd_addr_q;
  logic [CntW-1:0]            word_count_q;
  logic [beat_cnt_width-1:0]  beat_cnt_q;
  logic [dac_word_width-1:0]  pack_q;
  logic [dac_word_width-1:0]  word_d;
  logic                       beat_accept, last_beat, wr_en;

  assign s_axis_tready = load_en & select_in & (state_q == StIdle) &
                         (word_count_q < FullCount) & ~flush;
  assign beat_accept   = s_axis_tvalid & s_axis_tready;
  assign last_beat     = (beat_cnt_q == LastBeat);
  assign wr_en         = beat_accept & last_beat;

  // Current beat merged into the partial word so the final beat can be
  // written in the same cycle it is accepted.
  always_comb begin
    word_d = pack_q;
    for (int i = 0; i < int'(beats_per_word); i++) begin
      if (beat_cnt_q == beat_cnt_width'(i)) begin
        word_d[i*ps_axis_width +: ps_axis_width] = s_axis_tdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count_q <= '0;
      beat_cnt_q   <= '0;
      pack_q       <= '0;
    end else if (flush) begin
      word_count_q <= '0;
      beat_cnt_q   <= '0;
    end else if (!load_en) begin
      beat_cnt_q   <= '0;
    end else if (beat_accept) begin
      pack_q <= word_d;
      if (last_beat) begin
        beat_cnt_q   <= '0;
        word_count_q <= word_count_q + CntW'(1);
      end else begin
        beat_cnt_q <= beat_cnt_q + beat_cnt_width'(1);
      end
    end
  end

  // Playback FSM
  logic rd_en, rd_last;

  // Flush and load-enable rise stop reads in the cycle they are seen.
  assign rd_en   = (state_q == StPlay) & m_axis_tready & ~flush & ~load_rise;
  assign rd_last = ({1'b0, rd_addr_q} == (word_count_q - CntW'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      playing_q <= 1'b0;
      rd_addr_q <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      playing_q <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig_rise && (word_count_q != '0) && !load_en) begin
            state_q   <= StPlay;
            playing_q <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        StPlay: begin
          if (load_rise) begin
            state_q   <= StIdle;
            playing_q <= 1'b0;
            rd_addr_q <= '0;
          end else if (rd_en) begin
            if (rd_last) begin
              rd_addr_q <= '0;
              if (!loop_en) begin
                state_q   <= StIdle;
                playing_q <= 1'b0;
              end
            end else begin
              rd_addr_q <= rd_addr_q + AddrW'(1);
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage
  logic [dac_word_width-1:0] mem_rd_data;

  dac_wave_mem #(
    .AddrWidth (AddrW),
    .DataWidth (dac_word_width)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (word_count_q[AddrW-1:0]),
    .wr_data_i (word_d),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (mem_rd_data)
  );

  // Output pipeline: mem_vld_q tags the RAM output as a PLAY word; anything
  // else is replaced by zero at the output register. Whole pipe stalls on
  // m_axis_tready low.
  logic                      mem_vld_q;
  logic [dac_word_width-1:0] m_tdata_q;
  logic                      m_tvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_vld_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      m_tvalid_q <= 1'b1;
      if (m_axis_tready) begin
        mem_vld_q <= rd_en;
        m_tdata_q <= mem_vld_q ? mem_rd_data : '0;
      end
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign playing       = playing_q;
  assign word_count    = word_count_q;

endmodule

// File: doc/dac_wave_player.md
DAC_WAVE_PLAYER -- requirements
Module: dac_wave_player

Interface
REQ-001 Parameter mem_depth_log2, default 10, log2 of waveform memory depth in 128-bit words.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 gpio_ctrl_ext  input  16  control word from rfsoc_ctrl output.
REQ-005 s_axis_tdata  input  ps_axis_width  waveform beats from PS.
REQ-006 s_axis_tvalid  input  1  PS beat valid.
REQ-007 s_axis_tready  output  1  block accepts PS beat.
REQ-008 m_axis_tdata  output  128  sample word to DAC.
REQ-009 m_axis_tvalid  output  1  DAC word valid.
REQ-010 m_axis_tready  input  1  DAC accepts word.
REQ-011 select_in  input  1  channel select; loading is permitted only while high.
REQ-012 playing  output  1  high while FSM is in PLAY.
REQ-013 word_count  output  mem_depth_log2+1  number of stored 128-bit words.

Function
REQ-014 gpio_ctrl_ext SHALL be registered once into gpio_ctrl; all control decisions SHALL use gpio_ctrl.
REQ-015 Trigger SHALL be the rising edge of gpio_ctrl[trigger_line] (current vs. previous registered value).
REQ-016 s_axis_tready SHALL be high iff gpio_ctrl[dac_load_enable]=1, select_in=1, state=IDLE, word_count<2^mem_depth_log2, and flush is inactive.
REQ-017 Packing SHALL use 128/ps_axis_width beats per word; the first beat SHALL occupy the least-significant bits.
REQ-018 When the final beat of a word is accepted, the word SHALL be written at address word_count, and word_count SHALL increment on the same edge.
REQ-019 A partial pack SHALL be discarded and the beat counter cleared when dac_load_enable deasserts.
REQ-020 gpio_ctrl[dac_buffer_flush]=1 SHALL clear word_count, the beat counter and the read address, force IDLE, and take priority over all other events.
REQ-021 FSM states SHALL be IDLE and PLAY.
REQ-022 IDLE->PLAY SHALL occur on trigger when word_count>0 and dac_load_enable=0; otherwise the trigger SHALL be ignored.
REQ-023 In PLAY, read address 0..word_count-1 SHALL advance once per cycle with m_axis_tready=1.
REQ-024 After address word_count-1: if gpio_ctrl[dac_loop]=1, the address SHALL wrap to 0 with no gap; otherwise the FSM SHALL return to IDLE.
REQ-025 PLAY->IDLE SHALL occur immediately on flush or on dac_load_enable rising.
REQ-026 Memory read SHALL be 1-cycle registered, and m_axis_tdata SHALL be a further output register.
REQ-027 Latency: word 0 SHALL appear on m_axis_tdata 3 clk edges after the edge at which gpio_ctrl captures the trigger rise.
REQ-028 With m_axis_tready=0, address, memory output and m_axis_tdata SHALL hold, with no word lost or duplicated.
REQ-029 m_axis_tvalid SHALL be 1 at every edge after reset release.
REQ-030 m_axis_tdata SHALL be 0 whenever no PLAY word is in the pipeline, including 2 cycles after leaving PLAY.
REQ-031 A trigger during PLAY SHALL be ignored and SHALL NOT restart playback.

Reset
REQ-032 Asserting rst SHALL clear gpio_ctrl, FSM (IDLE), counters, pointers, m_axis_tdata, m_axis_tvalid, s_axis_tready and playing to 0 asynchronously.
REQ-033 Memory contents SHALL NOT be reset; word_count=0 SHALL make them unreachable.
REQ-034 Reset mid-PLAY SHALL output 0 at once and SHALL require a new trigger after release.

Structure
REQ-035 ps_axis_width and bit indices trigger_line, dac_load_enable, dac_buffer_flush and dac_loop SHALL reside in package rfsoc_config.
REQ-036 The FSM state typedef SHALL reside in rfsoc_config.
REQ-037 Waveform storage SHALL be one sub-module dac_wave_mem: simple dual-port 128-bit RAM, 2^mem_depth_log2 deep, registered read with read enable.

Verification
REQ-038 Load 8 beats 0x1..0x8 (32-bit), then trigger -> word_count=2, words 0x4_3_2_1 and 0x8_7_6_5 out, then 0, playing high exactly 2 cycles.
REQ-039 Trigger rise on gpio_ctrl_ext -> word 0 exactly 4 clk edges after the rise (1 capture + 3 latency).
REQ-040 dac_loop=1 with 3 words -> sequence w0,w1,w2,w0,w1,... with no gap; flush -> 0 output and word_count=0.
REQ-041 Toggle m_axis_tready 0/1 every other cycle in PLAY -> each word appears exactly once per accepted handshake, in order.
REQ-042 Fill 2^mem_depth_log2 words -> s_axis_tready drops; 3 beats then load_enable deasserted -> word_count unchanged.
REQ-043 Async rst mid-PLAY -> outputs 0 immediately; trigger while word_count=0 -> playing stays 0.
